// File: rtl/framer.sv
// framer: byte-stream frame encoder for the AXI4-Stream framing link.
// Each packet (delimited by target_tlast) is emitted as START_BYTE, the
// payload, then STOP_BYTE with initiator_tlast set. The output is a
// single registered beat, so initiator_tready never reaches
// initiator_tvalid combinationally.
// Optional feature macro: FRAMER_ESCAPE_EN. When it is defined, payload
// bytes equal to any delimiter or to the escape byte are sent as
// ESCAPE_BYTE followed by the byte itself. When it is undefined, the
// payload is forwarded unmodified and the sender must keep reserved
// bytes out of it.
module framer #(
    parameter logic [7:0] START_BYTE  = 8'h7D,
    parameter logic [7:0] STOP_BYTE   = 8'h7E,
    parameter logic [7:0] ESCAPE_BYTE = 8'h7F
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       target_tvalid,
    output logic       target_tready,
    input  logic [7:0] target_tdata,
    input  logic       target_tlast,
    output logic       initiator_tvalid,
    input  logic       initiator_tready,
    output logic [7:0] initiator_tdata,
    output logic       initiator_tlast
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ESC  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t     state_q;
    logic       tvalid_q;
    logic [7:0] tdata_q;
    logic       tlast_q;
    logic       out_free;

`ifdef FRAMER_ESCAPE_EN
    // Reserved byte waiting behind its escape prefix, with its last flag.
    logic [7:0] hold_data_q;
    logic       hold_last_q;

    function automatic logic is_reserved(input logic [7:0] b);
        return (b == START_BYTE) || (b == STOP_BYTE) || (b == ESCAPE_BYTE);
    endfunction
`endif

    // The output register can take a new beat when it is empty or being drained.
    assign out_free      = !tvalid_q || initiator_tready;
    assign target_tready = out_free && (state_q == S_DATA);

    assign initiator_tvalid = tvalid_q;
    assign initiator_tdata  = tdata_q;
    assign initiator_tlast  = tlast_q;

    // Frame sequencing FSM; every output beat is loaded into the registered stage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            tvalid_q    <= 1'b0;
            tdata_q     <= 8'h00;
            tlast_q     <= 1'b0;
`ifdef FRAMER_ESCAPE_EN
            hold_data_q <= 8'h00;
            hold_last_q <= 1'b0;
`endif
        end else if (out_free) begin
            // Default: the beat (if any) drains and nothing new is loaded.
            // tdata/tlast keep their old value while the register is empty.
            tvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Open a frame as soon as a payload byte is offered; the
                    // byte itself is consumed in DATA on the next cycle.
                    if (target_tvalid) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= START_BYTE;
                        tlast_q  <= 1'b0;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    // target_tready is high here, so valid means handshake.
                    if (target_tvalid) begin
`ifdef FRAMER_ESCAPE_EN
                        if (is_reserved(target_tdata)) begin
                            tvalid_q    <= 1'b1;
                            tdata_q     <= ESCAPE_BYTE;
                            tlast_q     <= 1'b0;
                            hold_data_q <= target_tdata;
                            hold_last_q <= target_tlast;
                            state_q     <= S_ESC;
                        end else
`endif
                        begin
                            tvalid_q <= 1'b1;
                            tdata_q  <= target_tdata;
                            tlast_q  <= 1'b0;
                            if (target_tlast) begin
                                state_q <= S_STOP;
                            end
                        end
                    end
                end
                S_ESC: begin
`ifdef FRAMER_ESCAPE_EN
                    // Send the reserved byte that followed the escape prefix.
                    tvalid_q <= 1'b1;
                    tdata_q  <= hold_data_q;
                    tlast_q  <= 1'b0;
                    state_q  <= hold_last_q ? S_STOP : S_DATA;
`else
                    state_q  <= S_IDLE;
`endif
                end
                S_STOP: begin
                    tvalid_q <= 1'b1;
                    tdata_q  <= STOP_BYTE;
                    tlast_q  <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framer.sv
// tb_framer: randomized and directed checks of framer against a
// frame-level reference model (START, escaped payload, STOP).
module tb_framer;

    logic       aclk;
    logic       areset;
    logic       target_tvalid;
    logic       target_tready;
    logic [7:0] target_tdata;
    logic       target_tlast;
    logic       initiator_tvalid;
    logic       initiator_tready;
    logic [7:0] initiator_tdata;
    logic       initiator_tlast;

    int n_cmp = 0;
    int n_err = 0;

    // Input beats still to be offered ({last, data}) and expected output beats.
    logic [8:0] in_q[$];
    logic [8:0] exp_q[$];
    bit         model_in_pkt = 0;

    framer dut (
        .aclk             (aclk),
        .areset           (areset),
        .target_tvalid    (target_tvalid),
        .target_tready    (target_tready),
        .target_tdata     (target_tdata),
        .target_tlast     (target_tlast),
        .initiator_tvalid (initiator_tvalid),
        .initiator_tready (initiator_tready),
        .initiator_tdata  (initiator_tdata),
        .initiator_tlast  (initiator_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic bit reserved(input logic [7:0] b);
        return (b == 8'h7D) || (b == 8'h7E) || (b == 8'h7F);
    endfunction

    // Reference model: queue one payload byte and the encoded beats it implies.
    task automatic add_byte(input logic [7:0] b, input logic l);
        in_q.push_back({l, b});
        if (!model_in_pkt) begin
            exp_q.push_back({1'b0, 8'h7D});
            model_in_pkt = 1;
        end
`ifdef FRAMER_ESCAPE_EN
        if (reserved(b)) exp_q.push_back({1'b0, 8'h7F});
`endif
        exp_q.push_back({1'b0, b});
        if (l) begin
            exp_q.push_back({1'b1, 8'h7E});
            model_in_pkt = 0;
        end
    endtask

    // Cycle-stepped driver/monitor. rdy_mode: 0 always ready, 1 toggle 1,0,..,
    // 2 random. vld_mode: 0 offer whenever data is queued, 1 random gaps.
    // stop_after > 0 ends the run once that many output beats are accepted.
    task automatic run_traffic(input int rdy_mode, input int vld_mode,
                               input int max_cycles, input int stop_after,
                               output int first_cyc, output int last_cyc,
                               output int nbeats, output int tready_hi);
        int         cyc;
        bit         stall_prev;
        logic [7:0] saved_data;
        logic       saved_last;
        logic [8:0] e;
        bit         in_hs, out_hs;
        cyc = 0; stall_prev = 0; saved_data = 0; saved_last = 0;
        first_cyc = -1; last_cyc = -1; nbeats = 0; tready_hi = 0;
        while (in_q.size() > 0 || exp_q.size() > 0) begin
            if (cyc >= max_cycles) begin
                n_cmp++; n_err++;
                $display("FAIL timeout: %0d inputs and %0d beats left after %0d cycles, required 0 left",
                         in_q.size(), exp_q.size(), cyc);
                in_q.delete(); exp_q.delete(); model_in_pkt = 0;
                break;
            end
            @(negedge aclk);
            if (in_q.size() > 0 && (vld_mode == 0 || $urandom_range(0, 1) == 1)) begin
                target_tvalid = 1'b1;
                target_tdata  = in_q[0][7:0];
                target_tlast  = in_q[0][8];
            end else begin
                target_tvalid = 1'b0;
                target_tdata  = 8'($urandom);
                target_tlast  = 1'($urandom);
            end
            case (rdy_mode)
                0:       initiator_tready = 1'b1;
                1:       initiator_tready = (cyc % 2 == 0);
                default: initiator_tready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (stall_prev) begin
                n_cmp++;
                if (initiator_tvalid !== 1'b1 || initiator_tdata !== saved_data ||
                    initiator_tlast !== saved_last) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             initiator_tvalid, initiator_tdata, initiator_tlast, saved_data, saved_last);
                end
            end
            if (target_tready === 1'b1) tready_hi++;
            in_hs  = target_tvalid && target_tready;
            out_hs = initiator_tvalid && initiator_tready;
            if (out_hs) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat: got d=%h l=%b, required no beat",
                             initiator_tdata, initiator_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if ({initiator_tlast, initiator_tdata} !== e) begin
                        n_err++;
                        $display("FAIL beat%0d: got d=%h l=%b, required d=%h l=%b",
                                 nbeats, initiator_tdata, initiator_tlast, e[7:0], e[8]);
                    end
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nbeats++;
            end
            stall_prev = initiator_tvalid && !initiator_tready;
            saved_data = initiator_tdata;
            saved_last = initiator_tlast;
            if (in_hs && in_q.size() > 0) void'(in_q.pop_front());
            cyc++;
            if (stop_after > 0 && nbeats >= stop_after) break;
        end
        @(negedge aclk);
        target_tvalid    = 1'b0;
        initiator_tready = 1'b1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        target_tvalid = 1'b1; target_tdata = 8'h11; target_tlast = 1'b0;
        initiator_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        target_tvalid = 1'b0;
        #1;
        n_cmp++;
        if (initiator_tvalid !== 1'b0 || initiator_tdata !== 8'h00 ||
            initiator_tlast !== 1'b0 || target_tready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b d=%h l=%b rdy=%b, required v=0 d=00 l=0 rdy=0",
                     initiator_tvalid, initiator_tdata, initiator_tlast, target_tready);
        end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_basic();
        int f, l, n, th;
        add_byte(8'h01, 0); add_byte(8'h02, 0); add_byte(8'h03, 1);
        run_traffic(0, 0, 100, 0, f, l, n, th);
        n_cmp++;
        if (f !== 1 || l - f !== 4 || n !== 5) begin
            n_err++;
            $display("FAIL basic_timing: got first=%0d span=%0d beats=%0d, required first=1 span=4 beats=5",
                     f, l - f, n);
        end
        n_cmp++;
        if (th !== 3) begin
            n_err++;
            $display("FAIL basic_tready: got %0d high cycles, required 3", th);
        end
        $display("test_basic: 01 02 03 -> %0d beats", n);
    endtask

    task automatic test_escape();
        int f, l, n, th;
`ifdef FRAMER_ESCAPE_EN
        add_byte(8'h7E, 0); add_byte(8'h55, 1);
        run_traffic(0, 0, 100, 0, f, l, n, th);
        n_cmp++;
        if (n !== 5 || l - f !== 4) begin
            n_err++;
            $display("FAIL esc_7e_count: got beats=%0d span=%0d, required beats=5 span=4", n, l - f);
        end
        add_byte(8'h7F, 1);
        run_traffic(0, 0, 100, 0, f, l, n, th);
        n_cmp++;
        if (n !== 4) begin
            n_err++;
            $display("FAIL esc_7f_count: got beats=%0d, required 4", n);
        end
`else
        add_byte(8'h7D, 0); add_byte(8'h05, 1);
        run_traffic(0, 0, 100, 0, f, l, n, th);
        n_cmp++;
        if (n !== 4) begin
            n_err++;
            $display("FAIL noesc_count: got beats=%0d, required 4", n);
        end
`endif
        $display("test_escape: last packet gave %0d beats", n);
    endtask

    task automatic test_stall_toggle();
        int f, l, n, th;
        add_byte(8'h10, 0); add_byte(8'h7D, 0); add_byte(8'h20, 1);
        run_traffic(1, 0, 200, 0, f, l, n, th);
        n_cmp++;
`ifdef FRAMER_ESCAPE_EN
        if (n !== 6) begin
            n_err++;
            $display("FAIL toggle_count: got beats=%0d, required 6", n);
        end
`else
        if (n !== 5) begin
            n_err++;
            $display("FAIL toggle_count: got beats=%0d, required 5", n);
        end
`endif
        $display("test_stall_toggle: %0d beats with toggling ready", n);
    endtask

    task automatic test_back_to_back();
        int f, l, n, th;
        add_byte(8'hAA, 1); add_byte(8'hBB, 1);
        run_traffic(0, 0, 100, 0, f, l, n, th);
        n_cmp++;
        if (n !== 6 || l - f !== 5) begin
            n_err++;
            $display("FAIL b2b_timing: got beats=%0d span=%0d, required beats=6 span=5", n, l - f);
        end
        $display("test_back_to_back: %0d beats over %0d cycles", n, l - f + 1);
    endtask

    task automatic test_reset_midframe();
        int f, l, n, th;
        add_byte(8'h01, 0); add_byte(8'h02, 1);
        run_traffic(0, 0, 100, 2, f, l, n, th);
        // The edge just past loaded 02; reset must drop valid without a clock.
        #2;
        areset = 1'b1;
        #1;
        n_cmp++;
        if (initiator_tvalid !== 1'b0 || target_tready !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_reset: got v=%b rdy=%b, required v=0 rdy=0",
                     initiator_tvalid, target_tready);
        end
        in_q.delete(); exp_q.delete(); model_in_pkt = 0;
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        add_byte(8'h0A, 1);
        run_traffic(0, 0, 100, 0, f, l, n, th);
        n_cmp++;
        if (n !== 3 || f !== 1) begin
            n_err++;
            $display("FAIL post_reset_frame: got beats=%0d first=%0d, required beats=3 first=1", n, f);
        end
        $display("test_reset_midframe: recovered frame of %0d beats", n);
    endtask

    task automatic test_random();
        int f, l, n, th, len, total;
        logic [7:0] b;
        total = 0;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
`ifdef FRAMER_ESCAPE_EN
                if ($urandom_range(0, 3) == 0) b = 8'(8'h7D + $urandom_range(0, 2));
                else b = 8'($urandom);
`else
                do b = 8'($urandom); while (reserved(b));
`endif
                add_byte(b, i == len - 1);
            end
        end
        total = exp_q.size();
        run_traffic(2, 1, 20000, 0, f, l, n, th);
        n_cmp++;
        if (n !== total) begin
            n_err++;
            $display("FAIL random_count: got beats=%0d, required %0d", n, total);
        end
        $display("test_random: 40 packets, %0d beats", n);
    endtask

    initial begin
        areset = 1'b1;
        target_tvalid = 1'b0; target_tdata = 8'h00; target_tlast = 1'b0;
        initiator_tready = 1'b1;
        test_reset();
        test_basic();
        test_escape();
        test_stall_toggle();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/framer.md
# framer

Byte-stream frame encoder on the transmit side of the AXI4-Stream framing link; it produces the stream the deframer consumes. Takes packets delimited by `target_tlast` and emits START_BYTE, the payload with reserved bytes escaped, then STOP_BYTE flagged with `initiator_tlast`. It uses a registered single-beat output stage, so it adds no combinational path from `initiator_tready` to `initiator_tvalid`.

## Interface
Parameters:
- `START_BYTE`, 8'h7D, frame-open delimiter
- `STOP_BYTE`, 8'h7E, frame-close delimiter
- `ESCAPE_BYTE`, 8'h7F, escape prefix

Ports:
- `aclk` in 1: clock.
- `areset` in 1: reset. One clock; reset is asynchronous and active-high.
- `target_tvalid` in 1: payload beat valid.
- `target_tready` out 1: payload beat accepted.
- `target_tdata` in 8: payload byte.
- `target_tlast` in 1: last payload byte of the packet.
- `initiator_tvalid` out 1: encoded beat valid.
- `initiator_tready` in 1: downstream ready.
- `initiator_tdata` out 8: encoded byte.
- `initiator_tlast` out 1: set only on the STOP_BYTE beat.

## Operation
- The output register is "free" when `!initiator_tvalid || initiator_tready`.
- When free and no load occurs, `initiator_tvalid` clears to 0.
- A load writes `initiator_tdata`, `initiator_tlast` and `initiator_tvalid=1`.
- `target_tready = free && state==DATA`. It is combinational and is never asserted in any other state.
- Reserved byte: equal to START_BYTE, STOP_BYTE or ESCAPE_BYTE.
- A hold register (8-bit byte plus last flag) stores a reserved byte while its escape prefix is sent.

FSM:
- IDLE:
  - If free and `target_tvalid`, load START_BYTE with tlast=0 and go to DATA.
  - The payload byte is not consumed in this cycle.
- DATA: on a target handshake with byte b and last l:
  - If b is reserved: load ESCAPE_BYTE, set hold to {b,l}, go to ESC.
  - Otherwise load b; go to STOP if l, else stay in DATA.
- ESC:
  - When free, load the held byte.
  - Go to STOP if the held last flag is set, else go to DATA.
- STOP:
  - When free, load STOP_BYTE with `initiator_tlast=1`, then go to IDLE.

Behaviour:
- A packet of N bytes containing k reserved bytes produces exactly N+k+2 output beats.
- A zero-length frame cannot be produced, because every frame carries at least one payload beat.
- Packets are never merged or split.
- Reset mid-frame: all state clears immediately. The partial frame is truncated with no STOP_BYTE; the downstream deframer resynchronises on the next START_BYTE.
- Input `tdata`/`tlast` are sampled only on a handshake. Changes while `target_tready=0` have no effect.

## Timing
- Reset values:
  - `initiator_tvalid`=0, `initiator_tdata`=8'h00, `initiator_tlast`=0.
  - `target_tready`=0 (state IDLE).
  - Hold register = 0.
- Latency: START_BYTE appears on the output the cycle after `target_tvalid` is seen in IDLE with the register free.
- The first payload byte appears 1 cycle after START_BYTE when `initiator_tready` is held at 1.
- Sustained throughput with `initiator_tready`=1: 1 beat per cycle, including escape and delimiter beats.
- Back-to-back packets: STOP_BYTE of packet n is directly followed by START_BYTE of packet n+1 with no bubble.
- While `initiator_tvalid=1 && !initiator_tready`, `initiator_tdata` and `initiator_tlast` hold stable (AXI4-Stream rule).
- A load and a downstream acceptance in the same cycle is legal and keeps the 1-beat-per-cycle rate.

## Configuration
- `FRAMER_ESCAPE_EN` defined:
  - Escape insertion and the ESC state are present, as described above.
- `FRAMER_ESCAPE_EN` undefined:
  - Every payload byte is forwarded unmodified, and the ESC state and hold register are removed.
  - The output is N+2 beats per packet.
  - The sender guarantees that no reserved bytes appear in the payload.

## Test plan
- Packet 01,02,03(last), `initiator_tready`=1 → output 7D,01,02,03,7E on 5 consecutive cycles, with tlast only on 7E. `target_tready` is high for exactly 3 cycles.
- Packet 7E,55(last) with `FRAMER_ESCAPE_EN` defined → 7D,7F,7E,55,7E. Packet 7F(last) → 7D,7F,7F,7E.
- Packet 10,7D,20(last) with `initiator_tready` toggling 1,0,1,0… → 7D,10,7F,7D,20,7E. Output tdata/tlast are unchanged during every stalled cycle.
- Back-to-back packets AA(last) and BB(last) with ready=1 → 7D,AA,7E,7D,BB,7E on 6 consecutive cycles.
- Reset mid-frame: `areset` pulses after 7D,01 are sent of packet 01,02(last).
  - Required response: `initiator_tvalid` drops in the same cycle.
  - The next packet 0A(last) then yields exactly 7D,0A,7E.
- `FRAMER_ESCAPE_EN` undefined: packet 7D,05(last) → 7D,7D,05,7E (4 beats).
